// File: rtl/rcv_bit_ctrl.sv
// ============================================================================
// Module     : rcv_bit_ctrl
// Description: UART receive timing/control: line synchronizer, start-bit
//              validation, mid-bit shift strobes, stop-bit check.
//              Optional even-parity check enabled by macro RCV_PARITY_EN.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rcv_bit_ctrl #(
  parameter int CLKS_PER_BIT  = 10,
  parameter int NUM_DATA_BITS = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  output logic serial_sync,
  output logic shift_enable,
  output logic load_buffer,
  output logic framing_error,
  output logic busy,
  output logic parity_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (NUM_DATA_BITS > 1) ? $clog2(NUM_DATA_BITS) : 1;

  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CLK_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CLK_ONE  = CW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NUM_DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

`ifdef RCV_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
  } state_t;
`endif

  state_t        state, state_nxt;
  logic          sync_meta;
  logic          sync_prev;
  logic [CW-1:0] clk_cnt, clk_cnt_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic          load_nxt;
  logic          ferr_nxt;

  // Reset high so a line already idling high never looks like an edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_meta   <= 1'b1;
      serial_sync <= 1'b1;
      sync_prev   <= 1'b1;
    end else begin
      sync_meta   <= serial_in;
      serial_sync <= sync_meta;
      sync_prev   <= serial_sync;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      load_buffer   <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      clk_cnt       <= clk_cnt_nxt;
      bit_cnt       <= bit_cnt_nxt;
      load_buffer   <= load_nxt;
      framing_error <= ferr_nxt;
      busy          <= (state_nxt != IDLE);
    end
  end

`ifdef RCV_PARITY_EN
  logic par_acc, par_acc_nxt;
  logic perr_nxt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      par_acc      <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      par_acc      <= par_acc_nxt;
      parity_error <= perr_nxt;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    clk_cnt_nxt  = clk_cnt;
    bit_cnt_nxt  = bit_cnt;
    load_nxt     = 1'b0;
    ferr_nxt     = framing_error;
    shift_enable = 1'b0;
`ifdef RCV_PARITY_EN
    par_acc_nxt  = par_acc;
    perr_nxt     = parity_error;
`endif

    case (state)
      IDLE: begin
        if (sync_prev && !serial_sync) begin
          state_nxt   = START;
          clk_cnt_nxt = '0;
        end
      end

      START: begin
        if (clk_cnt == CLK_HALF) begin
          clk_cnt_nxt = '0;
          if (!serial_sync) begin
            ferr_nxt    = 1'b0;
            bit_cnt_nxt = '0;
            state_nxt   = DATA;
`ifdef RCV_PARITY_EN
            perr_nxt    = 1'b0;
            par_acc_nxt = 1'b0;
`endif
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CLK_ONE;
        end
      end

      DATA: begin
        if (clk_cnt == CLK_LAST) begin
          shift_enable = 1'b1;
          clk_cnt_nxt  = '0;
`ifdef RCV_PARITY_EN
          par_acc_nxt  = par_acc ^ serial_sync;
`endif
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt = '0;
`ifdef RCV_PARITY_EN
            state_nxt   = PARITY;
`else
            state_nxt   = STOP;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_ONE;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CLK_ONE;
        end
      end

`ifdef RCV_PARITY_EN
      PARITY: begin
        if (clk_cnt == CLK_LAST) begin
          clk_cnt_nxt = '0;
          perr_nxt    = parity_error | (par_acc ^ serial_sync);
          state_nxt   = STOP;
        end else begin
          clk_cnt_nxt = clk_cnt + CLK_ONE;
        end
      end
`endif

      STOP: begin
        if (clk_cnt == CLK_LAST) begin
          clk_cnt_nxt = '0;
          state_nxt   = IDLE;
          if (serial_sync) begin
            load_nxt = 1'b1;
          end else begin
            ferr_nxt = 1'b1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CLK_ONE;
        end
      end

      default: begin
        state_nxt   = IDLE;
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_rcv_bit_ctrl.sv
// ============================================================================
// Module     : tb_rcv_bit_ctrl
// Description: Directed self-checking bench for rcv_bit_ctrl (10 clk/bit, 8 bits).
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rcv_bit_ctrl;

  localparam int CPB = 10;
`ifdef RCV_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic serial_in = 1'b1;
  logic serial_sync, shift_enable, load_buffer, framing_error, busy, parity_error;

  always #5 clk = ~clk;

  rcv_bit_ctrl #(.CLKS_PER_BIT(CPB), .NUM_DATA_BITS(8)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .serial_sync   (serial_sync),
    .shift_enable  (shift_enable),
    .load_buffer   (load_buffer),
    .framing_error (framing_error),
    .busy          (busy),
    .parity_error  (parity_error)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Downstream shift register model and pulse bookkeeping, sampled mid-cycle.
  int         cyc = 0;
  int         shift_total = 0;
  int         load_total = 0;
  int         overlap = 0;
  int         gap_err = 0;
  int         latency = -1;
  int         last_shift = 0;
  int         fall_cyc = 0;
  bit         first_pending = 1'b0;
  logic       prev_sync = 1'b1;
  logic [7:0] sreg = 8'h00;
  logic [7:0] load_hist [0:15];

  always @(negedge clk) begin
    cyc++;
    if (!busy && prev_sync && !serial_sync) begin
      fall_cyc      = cyc;
      first_pending = 1'b1;
    end
    if (shift_enable) begin
      sreg = {serial_sync, sreg[7:1]};
      if (first_pending) begin
        latency       = cyc - fall_cyc;
        first_pending = 1'b0;
      end else if (cyc - last_shift != CPB) begin
        gap_err++;
      end
      last_shift = cyc;
      shift_total++;
    end
    if (load_buffer) begin
      if (load_total < 16) load_hist[load_total] = sreg;
      load_total++;
    end
    if (shift_enable && load_buffer) overlap++;
    prev_sync = serial_sync;
  end

  task automatic bit_drive(input logic b);
    serial_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    bit_drive(1'b0);
    for (int i = 0; i < 8; i++) bit_drive(d[i]);
    if (HAS_PAR) bit_drive(par_b);
    bit_drive(stop_b);
  endtask

  int s0, l0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_serial_sync", serial_sync, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_shift", shift_enable, 1'b0);
    check_eq("rst_load", load_buffer, 1'b0);
    check_eq("rst_ferr", framing_error, 1'b0);
    check_eq("rst_perr", parity_error, 1'b0);
    n_rst = 1'b1;
    bit_drive(1'b1);
    bit_drive(1'b1);

    // Valid frame 0xA5
    s0 = shift_total; l0 = load_total;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    bit_drive(1'b1); bit_drive(1'b1);
    check_eq("a5_shifts", shift_total - s0, 8);
    check_eq("a5_loads", load_total - l0, 1);
    check_eq("a5_data", load_hist[l0], 8'hA5);
    check_eq("a5_ferr", framing_error, 1'b0);
    check_eq("a5_latency", latency, 15);
    check_eq("a5_busy_after", busy, 1'b0);

    // Glitch: 3 low cycles
    s0 = shift_total; l0 = load_total;
    serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    serial_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("glitch_busy_mid", busy, 1'b1);
    bit_drive(1'b1); bit_drive(1'b1); bit_drive(1'b1);
    check_eq("glitch_shifts", shift_total - s0, 0);
    check_eq("glitch_loads", load_total - l0, 0);
    check_eq("glitch_busy_after", busy, 1'b0);
    check_eq("glitch_ferr", framing_error, 1'b0);

    // Bad stop on 0x3C, then break held low
    s0 = shift_total; l0 = load_total;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    bit_drive(1'b0); bit_drive(1'b0);
    check_eq("bad_shifts", shift_total - s0, 8);
    check_eq("bad_loads", load_total - l0, 0);
    check_eq("bad_ferr", framing_error, 1'b1);
    check_eq("bad_data", sreg, 8'h3C);
    check_eq("break_busy", busy, 1'b0);
    bit_drive(1'b1); bit_drive(1'b1);

    // Recovery frame 0x00 clears the framing error
    l0 = load_total;
    send_frame(8'h00, 1'b1, 1'b0);
    bit_drive(1'b1); bit_drive(1'b1);
    check_eq("rec_loads", load_total - l0, 1);
    check_eq("rec_ferr", framing_error, 1'b0);
    check_eq("rec_data", load_hist[l0], 8'h00);

    // Back-to-back 0x55 then 0xFF
    s0 = shift_total; l0 = load_total;
    send_frame(8'h55, 1'b1, ^8'h55);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    bit_drive(1'b1); bit_drive(1'b1);
    check_eq("b2b_shifts", shift_total - s0, 16);
    check_eq("b2b_loads", load_total - l0, 2);
    check_eq("b2b_data0", load_hist[l0], 8'h55);
    check_eq("b2b_data1", load_hist[l0+1], 8'hFF);

    // Asynchronous reset mid-DATA
    bit_drive(1'b0); bit_drive(1'b1); bit_drive(1'b0);
    check_eq("mid_busy", busy, 1'b1);
    check_eq("mid_sync_low", serial_sync, 1'b0);
    #3;
    n_rst = 1'b0;
    #1;
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_sync", serial_sync, 1'b1);
    check_eq("arst_shift", shift_enable, 1'b0);
    check_eq("arst_load", load_buffer, 1'b0);
    serial_in = 1'b1;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    s0 = shift_total; l0 = load_total;
    bit_drive(1'b1); bit_drive(1'b1);
    check_eq("post_rst_busy", busy, 1'b0);
    check_eq("post_rst_shifts", shift_total - s0, 0);
    check_eq("post_rst_loads", load_total - l0, 0);

`ifdef RCV_PARITY_EN
    l0 = load_total;
    send_frame(8'h07, 1'b1, 1'b0);
    bit_drive(1'b1); bit_drive(1'b1);
    check_eq("par_bad_perr", parity_error, 1'b1);
    check_eq("par_bad_loads", load_total - l0, 1);
    l0 = load_total;
    send_frame(8'h07, 1'b1, 1'b1);
    bit_drive(1'b1); bit_drive(1'b1);
    check_eq("par_good_perr", parity_error, 1'b0);
    check_eq("par_good_loads", load_total - l0, 1);
`else
    check_eq("perr_tied", parity_error, 1'b0);
`endif

    check_eq("shift_load_overlap", overlap, 0);
    check_eq("shift_spacing", gap_err, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rcv_bit_ctrl.md
Name: rcv_bit_ctrl

Overview:
Receiver timing and control stage for the UART receive path. It sits directly upstream of the 8-bit receive shift register and drives that register's shift strobe and serial data. It synchronizes the raw serial line, detects and validates the start bit, and strobes one shift per data bit at mid-bit. It checks the stop bit, then pulses a buffer-load on a good frame or flags a framing error on a bad one.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit period; minimum 4, even values only.
NUM_DATA_BITS, 8, data bits per frame; must match the downstream shift register width.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
serial_in  input  1  raw asynchronous serial line; idles high
serial_sync  output  1  synchronized serial line; feeds the shift register data input
shift_enable  output  1  one-cycle strobe at the centre of each data bit
load_buffer  output  1  one-cycle pulse after a valid stop bit
framing_error  output  1  sticky flag; set on a bad stop bit
busy  output  1  high in every state except IDLE
parity_error  output  1  sticky flag; active only with PARITY_EN (see Optional Feature)

Behaviour:
- One clock; reset is asynchronous and active-low. Clock port is clk, reset port is n_rst.
- Reset values: both synchronizer flops = 1, serial_sync = 1, shift_enable = 0, load_buffer = 0, framing_error = 0, parity_error = 0, busy = 0, state = IDLE, all counters = 0.
- Synchronizer: 2-flop chain on serial_in, giving 2-cycle latency to serial_sync. A third flop holds the previous serial_sync for edge detection.
- Start detect: falling edge = previous serial_sync 1 and current serial_sync 0. Edge detection applies only in IDLE.
- Counters:
  - clk_cnt runs 0..CLKS_PER_BIT-1.
  - bit_cnt runs 0..NUM_DATA_BITS-1.
- FSM states: IDLE, START, DATA, STOP, plus PARITY when PARITY_EN is defined.
  - IDLE: on falling edge, go to START with clk_cnt = 0.
  - START: count to clk_cnt = CLKS_PER_BIT/2 - 1 (mid start bit).
    - If serial_sync = 0: start is valid. Clear framing_error and parity_error, set clk_cnt = 0 and bit_cnt = 0, go to DATA.
    - If serial_sync = 1: false start (glitch). Return to IDLE with no outputs and no flag change.
  - DATA: when clk_cnt = CLKS_PER_BIT-1, assert shift_enable for exactly that cycle and set clk_cnt = 0.
    - The shift register samples serial_sync on the edge that ends this cycle.
    - If bit_cnt = NUM_DATA_BITS-1, go to STOP (or PARITY); otherwise increment bit_cnt.
  - STOP: when clk_cnt = CLKS_PER_BIT-1, sample serial_sync, then go to IDLE.
    - Sample = 1: load_buffer high for one cycle.
    - Sample = 0: framing_error set, no load_buffer.
- Line-low at stop: IDLE rearms only after a fresh high-to-low transition, so a held-low line (break) starts no new frame.
- The first data-bit sample lands at 1.5 bit periods after the detected edge, i.e. mid data bit 0 (LSB first).
- shift_enable and load_buffer are never high in the same cycle. busy is a registered decode of state ≠ IDLE.
- Reset mid-frame: immediate return to IDLE with reset values; no partial load_buffer.

Optional Feature:
Macro: RCV_PARITY_EN.
- Defined:
  - PARITY state follows DATA and lasts one bit period.
  - A running XOR of every sampled data bit is kept, cleared at valid start.
  - At clk_cnt = CLKS_PER_BIT-1 in PARITY: if XOR(data) ^ serial_sync ≠ 0 (even parity), parity_error is set; go to STOP.
  - On a good stop bit, load_buffer still pulses even with a parity error.
- Undefined: no PARITY state, no XOR logic; parity_error is tied to 0.

Test Plan:
All scenarios use CLKS_PER_BIT = 10 and NUM_DATA_BITS = 8.
- Reset: assert n_rst = 0 mid-DATA -> all outputs are at reset values immediately (asynchronously); after release, busy = 0 and no shift_enable.
- Valid frame 0xA5 (start 0, bits LSB-first 1,0,1,0,0,1,0,1, stop 1) -> exactly 8 shift_enable pulses spaced 10 cycles apart, the first 15 cycles after the first low serial_sync; one load_buffer pulse; downstream register reads 0xA5; framing_error = 0.
- Glitch: serial_in low for 3 cycles, then high -> state returns to IDLE at mid-start; zero shift_enable, zero load_buffer.
- Bad stop: frame 0x3C with stop bit 0 -> 8 shift_enable pulses, no load_buffer, framing_error = 1. Line returned high, then a valid frame 0x00 -> framing_error clears at its valid start; load_buffer pulses.
- Back-to-back frames 0x55 then 0xFF with no idle gap beyond the stop bit -> both frames load; 16 shift_enable pulses, 2 load_buffer pulses.
- RCV_PARITY_EN: frame 0x07 with parity bit 0 (wrong, odd count) -> parity_error = 1 and load_buffer pulses. Same frame with parity bit 1 -> parity_error = 0.
